// File: rtl/mul8_acc_stage.sv
// Streaming accumulator for unsigned 16-bit products from the mul8 stage.
// Each vector's sum, beat count and sticky overflow go out through a valid/ready result register.
module mul8_acc_stage #(
  parameter int ACC_W   = 24,
  parameter int MAX_LEN = 256,
  parameter int SAT     = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  // Returns the value stored after an add.
  // With SAT set, the sum pins at all-ones once the vector has overflowed.
  function automatic logic [ACC_W-1:0] sat_sum(input logic [ACC_W:0] s, input logic o);
    logic [ACC_W-1:0] r;
    if ((SAT != 0) && o) r = '1;
    else                 r = s[ACC_W-1:0];
    return r;
  endfunction

  logic [ACC_W-1:0] acc_p0;
  logic [CNT_W-1:0] cnt_p0;
  logic             ovf_p0;

  logic [ACC_W-1:0] sum_p1;
  logic [CNT_W-1:0] count_p1;
  logic             ovf_p1;
  logic             vld_p1;

  logic [ACC_W:0]   nsum;
  logic [ACC_W-1:0] nval;
  logic [CNT_W-1:0] ncnt;
  logic             novf;
  logic             in_xfer;
  logic             out_xfer;
  logic             eov;

  assign in_ready = ~vld_p1 | out_ready;
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = vld_p1 & out_ready;

  always_comb begin
    nsum = {1'b0, acc_p0} + {{(ACC_W-15){1'b0}}, in_prod};
    novf = ovf_p0 | nsum[ACC_W];
    ncnt = cnt_p0 + CNT_W'(1);
    nval = sat_sum(nsum, novf);
    eov  = in_xfer & (in_last | (ncnt == CNT_W'(MAX_LEN)));
  end

  // Stage p0: running accumulator of the vector in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_p0 <= '0;
      cnt_p0 <= '0;
      ovf_p0 <= 1'b0;
    end else if (eov) begin
      acc_p0 <= '0;
      cnt_p0 <= '0;
      ovf_p0 <= 1'b0;
    end else if (in_xfer) begin
      acc_p0 <= nval;
      cnt_p0 <= ncnt;
      ovf_p0 <= novf;
    end
  end

  // Stage p1: result register; a new result may replace the one leaving in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_p1   <= '0;
      count_p1 <= '0;
      ovf_p1   <= 1'b0;
      vld_p1   <= 1'b0;
    end else if (eov) begin
      sum_p1   <= nval;
      count_p1 <= ncnt;
      ovf_p1   <= novf;
      vld_p1   <= 1'b1;
    end else if (out_xfer) begin
      vld_p1   <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign out_sum   = sum_p1;
  assign out_count = count_p1;
  assign out_ovf   = ovf_p1;

endmodule

// File: tb/tb_mul8_acc_stage.sv
// Directed bench for mul8_acc_stage: four parameterisations share one stimulus stream,
// each checked every cycle against an integer-arithmetic model plus hand-computed values.
module tb_mul8_acc_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_prod;
  logic        in_last;
  logic        out_ready;

  // 0: ACC_W=24 SAT=1 MAX_LEN=256   1: ACC_W=17 SAT=1   2: ACC_W=17 SAT=0   3: MAX_LEN=4
  int W[4]  = '{24, 17, 17, 24};
  int ML[4] = '{256, 256, 256, 4};
  int S[4]  = '{1, 1, 0, 1};

  logic        rdy0, rdy1, rdy2, rdy3;
  logic        ov0, ov1, ov2, ov3;
  logic [23:0] sum0, sum3;
  logic [16:0] sum1, sum2;
  logic [15:0] cnt0, cnt1, cnt2, cnt3;
  logic        of0, of1, of2, of3;

  mul8_acc_stage #(.ACC_W(24), .MAX_LEN(256), .SAT(1), .CNT_W(16)) d0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_prod(in_prod),
    .in_last(in_last), .out_valid(ov0), .out_ready(out_ready), .out_sum(sum0),
    .out_count(cnt0), .out_ovf(of0));
  mul8_acc_stage #(.ACC_W(17), .MAX_LEN(256), .SAT(1), .CNT_W(16)) d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_prod(in_prod),
    .in_last(in_last), .out_valid(ov1), .out_ready(out_ready), .out_sum(sum1),
    .out_count(cnt1), .out_ovf(of1));
  mul8_acc_stage #(.ACC_W(17), .MAX_LEN(256), .SAT(0), .CNT_W(16)) d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .in_prod(in_prod),
    .in_last(in_last), .out_valid(ov2), .out_ready(out_ready), .out_sum(sum2),
    .out_count(cnt2), .out_ovf(of2));
  mul8_acc_stage #(.ACC_W(24), .MAX_LEN(4), .SAT(1), .CNT_W(16)) d3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy3), .in_prod(in_prod),
    .in_last(in_last), .out_valid(ov3), .out_ready(out_ready), .out_sum(sum3),
    .out_count(cnt3), .out_ovf(of3));

  longint d_sum[4];
  longint d_cnt[4];
  bit     d_ov[4];
  bit     d_of[4];
  bit     d_rdy[4];

  always_comb begin
    d_sum[0] = longint'(sum0); d_sum[1] = longint'(sum1);
    d_sum[2] = longint'(sum2); d_sum[3] = longint'(sum3);
    d_cnt[0] = longint'(cnt0); d_cnt[1] = longint'(cnt1);
    d_cnt[2] = longint'(cnt2); d_cnt[3] = longint'(cnt3);
    d_ov[0] = ov0; d_ov[1] = ov1; d_ov[2] = ov2; d_ov[3] = ov3;
    d_of[0] = of0; d_of[1] = of1; d_of[2] = of2; d_of[3] = of3;
    d_rdy[0] = rdy0; d_rdy[1] = rdy1; d_rdy[2] = rdy2; d_rdy[3] = rdy3;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int k, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[dut%0d] at %0t: got %0d, expected %0d", nm, k, $time, act, exp);
    end
  endtask

  // Behavioural model: integer sums, overflow when the true sum reaches 2^ACC_W
  longint m_acc[4]   = '{0, 0, 0, 0};
  int     m_cnt[4]   = '{0, 0, 0, 0};
  bit     m_ovf[4]   = '{0, 0, 0, 0};
  bit     m_vld[4]   = '{0, 0, 0, 0};
  longint m_sum[4]   = '{0, 0, 0, 0};
  int     m_count[4] = '{0, 0, 0, 0};
  bit     m_oovf[4]  = '{0, 0, 0, 0};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        m_acc[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0;
        m_vld[k] = 0; m_sum[k] = 0; m_count[k] = 0; m_oovf[k] = 0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        longint lim;
        longint s;
        bit     accept;
        bit     done;
        lim    = longint'(1) << W[k];
        accept = in_valid && (!m_vld[k] || out_ready);
        done   = 0;
        if (accept) begin
          s = m_acc[k] + longint'(in_prod);
          m_cnt[k]++;
          if (s >= lim) begin
            m_ovf[k] = 1;
            s = s - lim;
          end
          if (S[k] != 0 && m_ovf[k]) s = lim - 1;
          m_acc[k] = s;
          if (in_last || m_cnt[k] == ML[k]) begin
            m_sum[k] = m_acc[k]; m_count[k] = m_cnt[k]; m_oovf[k] = m_ovf[k];
            m_vld[k] = 1; done = 1;
            m_acc[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0;
          end
        end
        if (!done && m_vld[k] && out_ready) m_vld[k] = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        chk("out_valid", k, longint'(d_ov[k]), longint'(m_vld[k]));
        chk("in_ready", k, longint'(d_rdy[k]), longint'(!m_vld[k] || out_ready));
        chk("out_sum", k, d_sum[k], m_sum[k]);
        chk("out_count", k, d_cnt[k], longint'(m_count[k]));
        chk("out_ovf", k, longint'(d_of[k]), longint'(m_oovf[k]));
      end
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input bit v, input logic [15:0] p, input bit l, input bit r);
    in_valid = v; in_prod = p; in_last = l; out_ready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_prod = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    chk("rst_valid", 0, longint'(ov0), 0);
    chk("rst_ready", 0, longint'(rdy0), 1);
    chk("rst_sum", 0, longint'(sum0), 0);
    chk("rst_count", 0, longint'(cnt0), 0);
    @(posedge clk); #1;

    // 100+200+300+400
    step(1, 100, 0, 1); step(1, 200, 0, 1); step(1, 300, 0, 1); step(1, 400, 1, 1);
    chk("t1_valid", 0, longint'(ov0), 1);
    chk("t1_sum", 0, longint'(sum0), 1000);
    chk("t1_count", 0, longint'(cnt0), 4);
    chk("t1_ovf", 0, longint'(of0), 0);
    step(0, 0, 0, 1);
    chk("t1_drop", 0, longint'(ov0), 0);

    // three full-scale products overflow a 17-bit accumulator
    step(1, 16'hFFFF, 0, 1); step(1, 16'hFFFF, 0, 1); step(1, 16'hFFFF, 1, 1);
    chk("t2_sat_sum", 1, longint'(sum1), 131071);
    chk("t2_sat_ovf", 1, longint'(of1), 1);
    chk("t2_sat_count", 1, longint'(cnt1), 3);
    chk("t2_wrap_sum", 2, longint'(sum2), 65533);
    chk("t2_wrap_ovf", 2, longint'(of2), 1);
    chk("t2_wide_sum", 0, longint'(sum0), 196605);
    step(0, 0, 0, 1);

    // MAX_LEN=4 forces the vector end without in_last
    for (int i = 1; i <= 6; i++) begin
      step(1, 1, 0, 1);
      if (i == 4) begin
        chk("t3_valid", 3, longint'(ov3), 1);
        chk("t3_sum", 3, longint'(sum3), 4);
        chk("t3_count", 3, longint'(cnt3), 4);
        chk("t3_long_busy", 0, longint'(ov0), 0);
      end
    end
    chk("t3_no_out", 3, longint'(ov3), 0);
    step(1, 0, 1, 1);
    chk("t3_tail_sum", 3, longint'(sum3), 2);
    chk("t3_tail_count", 3, longint'(cnt3), 3);
    chk("t3_long_count", 0, longint'(cnt0), 7);
    step(0, 0, 0, 1);

    // stalled result of sum 10, then drain together with a 1-beat vector
    step(1, 1, 0, 0); step(1, 2, 0, 0); step(1, 3, 0, 0); step(1, 4, 1, 0);
    chk("t4_sum", 0, longint'(sum0), 10);
    chk("t4_ready", 0, longint'(rdy0), 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 99, 1, 0);
      chk("t4_hold_sum", 0, longint'(sum0), 10);
      chk("t4_hold_count", 0, longint'(cnt0), 4);
      chk("t4_hold_valid", 0, longint'(ov0), 1);
      chk("t4_hold_ready", 0, longint'(rdy0), 0);
    end
    step(1, 7, 1, 1);
    chk("t4_new_sum", 0, longint'(sum0), 7);
    chk("t4_new_count", 0, longint'(cnt0), 1);
    chk("t4_new_valid", 0, longint'(ov0), 1);
    step(0, 0, 0, 1);
    chk("t4_drop", 0, longint'(ov0), 0);

    // asynchronous reset mid-vector
    step(1, 50, 0, 1); step(1, 60, 0, 1);
    in_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("t5_valid", 0, longint'(ov0), 0);
    chk("t5_sum", 0, longint'(sum0), 0);
    chk("t5_count", 0, longint'(cnt0), 0);
    chk("t5_sum_w17", 1, longint'(sum1), 0);
    #2 rst = 1'b0;
    step(1, 5, 1, 1);
    chk("t5_after_sum", 0, longint'(sum0), 5);
    chk("t5_after_count", 0, longint'(cnt0), 1);
    chk("t5_after_valid", 0, longint'(ov0), 1);

    // continuous 1-beat vectors
    for (int p = 1; p <= 20; p++) begin
      step(1, 16'(p), 1, 1);
      chk("t6_sum", 0, longint'(sum0), longint'(p));
      chk("t6_count", 0, longint'(cnt0), 1);
      chk("t6_valid", 0, longint'(ov0), 1);
      chk("t6_ready", 0, longint'(rdy0), 1);
    end
    step(0, 0, 0, 1);
    chk("t6_drop", 0, longint'(ov0), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul8_acc_stage.md
Name: mul8_acc_stage

Overview:
- Streaming accumulator directly downstream of the 8x8 approximate multipliers.
- Consumes one unsigned 16-bit product per accepted beat and sums a vector of products.
- Emits the sum, beat count and overflow flag through a valid/ready output register.
- Used to measure dot-product behaviour of approximate multipliers in accumulation chains.

Parameters:
ACC_W, 24, accumulator and result width in bits; legal range 17..32
MAX_LEN, 256, maximum beats per vector; reaching it forces vector end; legal range 2..65535
SAT, 1, 1 = saturate the sum to all-ones on overflow; 0 = wrap modulo 2^ACC_W
CNT_W, 16, width of the beat counter; must satisfy 2^CNT_W > MAX_LEN

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  product beat valid
in_ready  output  1  stage can accept a beat
in_prod  input  16  unsigned product from the mul8 stage (O[15:0])
in_last  input  1  beat is the final beat of the current vector
out_valid  output  1  result register holds a completed vector
out_ready  input  1  consumer accepts the result
out_sum  output  ACC_W  accumulated sum of the vector
out_count  output  CNT_W  number of beats in the vector (1..MAX_LEN)
out_ovf  output  1  sum overflowed ACC_W at some point in the vector (sticky per vector)

Behaviour:
- Reset (async, any time, including mid-vector):
  - acc = 0, cnt = 0, ovf = 0.
  - out_valid = 0, out_sum = 0, out_count = 0, out_ovf = 0.
  - The partial vector is discarded. in_ready is 1 in the first cycle after reset deasserts.
- Handshake:
  - in_ready = ~out_valid | out_ready (combinational from out_ready; no other dependency).
  - A beat transfers when in_valid & in_ready.
  - The result transfers when out_valid & out_ready.
  - in_prod, in_last, in_valid are ignored when no transfer occurs.
- Accumulate on each input transfer:
  - nsum = acc + zero-extend(in_prod), computed at ACC_W+1 bits; carry = nsum[ACC_W].
  - ncnt = cnt + 1.
  - novf = ovf | carry.
  - On carry: if SAT=1, the stored value is all-ones; once saturated, the value stays all-ones for the rest of the vector. If SAT=0, the stored value is nsum[ACC_W-1:0].
- End of vector: a transfer with in_last = 1, or a transfer with ncnt == MAX_LEN (in_last is then irrelevant).
  - out_sum <= stored value, out_count <= ncnt, out_ovf <= novf, out_valid <= 1.
  - acc, cnt, ovf clear to 0 in the same edge.
  - Latency: the result is visible the cycle after the last beat transfers.
- Non-final transfer: acc, cnt, ovf update; output register unchanged.
- Output register:
  - out_valid falls only on a result transfer with no simultaneous end-of-vector input transfer.
  - Result transfer and end-of-vector input transfer in the same cycle: the new result overwrites, out_valid stays 1 (full throughput, no bubble).
  - While out_valid = 1 and out_ready = 0, all output fields hold stable and in_ready = 0.
- States (implicit): EMPTY (out_valid=0), FULL (out_valid=1). The accumulator is independent and continues across output stalls only when in_ready permits.
- Single-beat vectors (in_last on the first beat) are legal: out_count = 1.
- No back-to-back restriction: a new vector's first beat may transfer the cycle after the previous last beat.

Test Plan:
- Reset, then 4 beats of products 100, 200, 300, 400 with in_last on the 4th and out_ready = 1 -> next cycle out_valid = 1, out_sum = 1000, out_count = 4, out_ovf = 0; out_valid drops one cycle later.
- ACC_W = 17, SAT = 1, beats 65535, 65535, 65535 (last) -> out_sum = 131071, out_count = 3, out_ovf = 1. With SAT = 0 -> out_sum = 65533, out_ovf = 1.
- MAX_LEN = 4, 6 beats of value 1 with in_last never asserted -> first result sum = 4, count = 4; second vector holds 2 beats in progress with no output.
- out_ready = 0 after a completed vector of sum 10 -> in_ready = 0, output fields hold for 5 cycles; raise out_ready together with an in_last beat of 7 that is the final beat of a 1-beat vector -> next cycle out_sum = 7, out_count = 1, out_valid stays 1.
- Assert rst asynchronously after 2 of 3 beats (50, 60) -> out_valid = 0 immediately; after release, beat 5 with in_last -> out_sum = 5, out_count = 1.
- Continuous stream of 1-beat vectors, in_valid = 1 and out_ready = 1 every cycle, products 1, 2, 3, ... -> one result per cycle, out_sum sequence matches inputs delayed by 1 cycle, in_ready constantly 1.
